// File: rtl/lsu_dmem_ctrl.sv
// Load/store controller between the RV32I memory stage and a four-lane byte-banked data memory.
// Generates lane enables and replicated store data, sequences read latency and extends load data.
module lsu_dmem_ctrl #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned DMEM_WIDTH   = 12,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [XLEN-1:0]       req_addr,
   input  logic [XLEN-1:0]       req_wdata,
   output logic                  resp_valid,
   output logic [XLEN-1:0]       resp_rdata,
   output logic                  resp_misaligned,
   output logic                  resp_illegal,
   output logic [DMEM_WIDTH-1:0] mem_address,
   output logic [XLEN-1:0]       mem_data,
   output logic [3:0]            mem_byteena,
   output logic                  mem_rden,
   output logic                  mem_wren,
   input  logic [XLEN-1:0]       mem_q
);

   localparam int unsigned CNT_W = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_CAPTURE,
      S_DONE,
      S_ERR
   } state_t;

   state_t             state_q;
   state_t             state_next;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_next;
   logic [2:0]         f3_q;
   logic [1:0]         lo_q;

   logic               accept_c;
   logic               illegal_c;
   logic               misaligned_c;
   logic               legal_c;
   logic [3:0]         byteena_c;
   logic [XLEN-1:0]    wdata_c;
   logic [XLEN-1:0]    shifted_c;
   logic [XLEN-1:0]    load_c;
   logic               unused_addr_c;

   // Upper address bits are dropped so accesses wrap modulo memory size.
   assign unused_addr_c = ^req_addr[XLEN-1:DMEM_WIDTH+2];

   assign accept_c = req_valid && req_ready;
   assign legal_c  = accept_c && !illegal_c && !misaligned_c;

   // Request decode: legality, alignment, lane pattern and replicated store data.
   always_comb begin
      illegal_c    = 1'b1;
      misaligned_c = 1'b0;
      byteena_c    = 4'b0000;
      wdata_c      = req_wdata;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: illegal_c = 1'b0;
         3'b100, 3'b101:         illegal_c = req_we;
         default:                illegal_c = 1'b1;
      endcase
      case (req_funct3[1:0])
         2'b00: begin
            byteena_c = 4'b0001 << req_addr[1:0];
            wdata_c   = {(XLEN/8){req_wdata[7:0]}};
         end
         2'b01: begin
            misaligned_c = req_addr[0];
            byteena_c    = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c      = {(XLEN/16){req_wdata[15:0]}};
         end
         2'b10: begin
            misaligned_c = |req_addr[1:0];
            byteena_c    = 4'b1111;
         end
         default: ;
      endcase
   end

   // Load alignment and extension from the captured offset and funct3.
   always_comb begin
      shifted_c = mem_q >> {lo_q, 3'b000};
      case (f3_q)
         3'b000:  load_c = {{(XLEN-8){shifted_c[7]}}, shifted_c[7:0]};
         3'b001:  load_c = {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
         3'b100:  load_c = {{(XLEN-8){1'b0}}, shifted_c[7:0]};
         3'b101:  load_c = {{(XLEN-16){1'b0}}, shifted_c[15:0]};
         default: load_c = shifted_c;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_next;
         cnt_q   <= cnt_next;
      end
   end

   // Next state; READ dwells READ_LATENCY cycles.
   always_comb begin
      state_next = state_q;
      cnt_next   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               if (illegal_c || misaligned_c) begin
                  state_next = S_ERR;
               end else if (req_we) begin
                  state_next = S_WRITE;
               end else begin
                  state_next = S_READ;
                  cnt_next   = '0;
               end
            end
         end
         S_WRITE:   state_next = S_DONE;
         S_READ: begin
            if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
               state_next = S_CAPTURE;
            end else begin
               cnt_next = cnt_q + CNT_W'(1);
            end
         end
         S_CAPTURE: state_next = S_DONE;
         S_DONE:    state_next = S_IDLE;
         S_ERR:     state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Registered outputs derived from the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready       <= 1'b0;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
         resp_illegal    <= 1'b0;
         mem_address     <= '0;
         mem_data        <= '0;
         mem_byteena     <= 4'b0000;
         mem_rden        <= 1'b0;
         mem_wren        <= 1'b0;
         f3_q            <= 3'b000;
         lo_q            <= 2'b00;
      end else begin
         req_ready       <= (state_next == S_IDLE);
         resp_valid      <= (state_next == S_DONE) || (state_next == S_ERR);
         resp_illegal    <= (state_next == S_ERR) && illegal_c;
         resp_misaligned <= (state_next == S_ERR) && !illegal_c && misaligned_c;
         mem_rden        <= (state_next == S_READ);
         mem_wren        <= (state_next == S_WRITE);
         if (legal_c) begin
            mem_address <= req_addr[DMEM_WIDTH+1:2];
            mem_byteena <= byteena_c;
            mem_data    <= wdata_c;
            f3_q        <= req_funct3;
            lo_q        <= req_addr[1:0];
         end
         if (state_q == S_CAPTURE) begin
            resp_rdata <= load_c;
         end
      end
   end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Bench for lsu_dmem_ctrl: instances with read latency 1 and 2, a byte-level reference
// memory, directed corner cases and random load/store traffic.
module tb_lsu_dmem_ctrl;

   localparam int unsigned NI = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic        req_valid       [NI];
   logic        req_ready       [NI];
   logic        req_we          [NI];
   logic [2:0]  req_funct3      [NI];
   logic [31:0] req_addr        [NI];
   logic [31:0] req_wdata       [NI];
   logic        resp_valid      [NI];
   logic [31:0] resp_rdata      [NI];
   logic        resp_misaligned [NI];
   logic        resp_illegal    [NI];
   logic [11:0] mem_address     [NI];
   logic [31:0] mem_data        [NI];
   logic [3:0]  mem_byteena     [NI];
   logic        mem_rden        [NI];
   logic        mem_wren        [NI];
   logic [31:0] mem_q           [NI];

   logic [31:0] ram     [NI][4096]  = '{default: '0};
   logic [31:0] rd_s1;
   logic [7:0]  ref_mem [NI][16384] = '{default: '0};
   logic [31:0] ref_rdata [NI];

   int n_checks = 0;
   int n_errors = 0;
   int cur_d    = 0;

   always #5 clk = ~clk;

   lsu_dmem_ctrl #(.XLEN(32), .DMEM_WIDTH(12), .READ_LATENCY(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
      .resp_misaligned(resp_misaligned[0]), .resp_illegal(resp_illegal[0]),
      .mem_address(mem_address[0]), .mem_data(mem_data[0]), .mem_byteena(mem_byteena[0]),
      .mem_rden(mem_rden[0]), .mem_wren(mem_wren[0]), .mem_q(mem_q[0])
   );

   lsu_dmem_ctrl #(.XLEN(32), .DMEM_WIDTH(12), .READ_LATENCY(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
      .resp_misaligned(resp_misaligned[1]), .resp_illegal(resp_illegal[1]),
      .mem_address(mem_address[1]), .mem_data(mem_data[1]), .mem_byteena(mem_byteena[1]),
      .mem_rden(mem_rden[1]), .mem_wren(mem_wren[1]), .mem_q(mem_q[1])
   );

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
      return m;
   endfunction

   // Memory stub: byte-lane writes, reads masked by lane enables, junk when not reading.
   always @(posedge clk) begin
      for (int d = 0; d < NI; d++) begin
         if (mem_wren[d]) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_byteena[d][b]) ram[d][mem_address[d]][8*b +: 8] <= mem_data[d][8*b +: 8];
            end
         end
      end
      mem_q[0] <= mem_rden[0] ? (ram[0][mem_address[0]] & lane_mask(mem_byteena[0])) : 32'hDEAD_BEEF;
      rd_s1    <= mem_rden[1] ? (ram[1][mem_address[1]] & lane_mask(mem_byteena[1])) : 32'hBAAD_F00D;
      mem_q[1] <= rd_s1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL u%0d.%s: observed 0x%08h expected 0x%08h", cur_d, tag, obs, expv);
      end
   endtask

   function automatic bit f3_illegal(input logic we, input logic [2:0] f3);
      if (we) return f3 > 3'd2;
      return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
   endfunction

   // Reference load value assembled from the byte model and extended.
   function automatic logic [31:0] model_load(input int d, input logic [2:0] f3, input logic [31:0] addr);
      int unsigned size;
      logic [31:0] v;
      size = 32'd1 << f3[1:0];
      v    = '0;
      for (int unsigned i = 0; i < size; i++) v[8*i +: 8] = ref_mem[d][(addr + i) % 16384];
      if (size < 4 && f3[2] == 1'b0 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      return v;
   endfunction

   task automatic wait_ready(input int d);
      int k;
      k = 0;
      cur_d = d;
      while (!req_ready[d] && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("ready_wait", 32'(req_ready[d]), 32'd1);
   endtask

   // One complete request with per-cycle checks against the reference model.
   task automatic run_req(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
      int unsigned size, lat, n, word_addr;
      bit ill, mis, err, is_load;
      logic [3:0]  be;
      logic [31:0] mdata, ldval, old_rdata;
      size      = 32'd1 << f3[1:0];
      ill       = f3_illegal(we, f3);
      mis       = (addr % size) != 0;
      err       = ill || mis;
      is_load   = !err && !we;
      lat       = (d == 0) ? 1 : 2;
      n         = err ? 2 : (we ? 3 : lat + 3);
      word_addr = (addr >> 2) % 4096;
      be        = '0;
      mdata     = '0;
      ldval     = '0;
      if (!err) begin
         for (int unsigned i = 0; i < size; i++) be[(addr % 4) + i] = 1'b1;
         for (int unsigned j = 0; j < 4; j++) mdata[8*j +: 8] = wdata[8*(j % size) +: 8];
         ldval = model_load(d, f3, addr);
      end
      old_rdata = ref_rdata[d];
      wait_ready(d);
      req_valid[d]  = 1'b1;
      req_we[d]     = we;
      req_funct3[d] = f3;
      req_addr[d]   = addr;
      req_wdata[d]  = wdata;
      @(posedge clk); #1;
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'($urandom);
      req_funct3[d] = 3'($urandom);
      req_addr[d]   = $urandom;
      req_wdata[d]  = $urandom;
      for (int unsigned c = 1; c <= n; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         check("req_ready", 32'(req_ready[d]), 32'(c == n));
         check("resp_valid", 32'(resp_valid[d]), 32'(c == n - 1));
         check("resp_illegal", 32'(resp_illegal[d]), 32'((c == n - 1) && ill));
         check("resp_misaligned", 32'(resp_misaligned[d]), 32'((c == n - 1) && !ill && mis));
         check("mem_wren", 32'(mem_wren[d]), 32'(!err && we && c == 1));
         check("mem_rden", 32'(mem_rden[d]), 32'(is_load && c <= lat));
         check("resp_rdata", resp_rdata[d], (is_load && c >= lat + 2) ? ldval : old_rdata);
         if (!err && c <= (we ? 1 : lat + 1)) begin
            check("mem_address", 32'(mem_address[d]), word_addr);
            check("mem_byteena", 32'(mem_byteena[d]), 32'(be));
            if (we) check("mem_data", mem_data[d], mdata);
         end
      end
      if (!err && we) begin
         for (int unsigned i = 0; i < size; i++) ref_mem[d][(addr + i) % 16384] = wdata[8*i +: 8];
      end
      if (is_load) ref_rdata[d] = ldval;
   endtask

   initial begin
      logic [31:0] a, b, lda, ldb, ra;
      for (int d = 0; d < NI; d++) begin
         req_valid[d]  = 1'b0;
         req_we[d]     = 1'b0;
         req_funct3[d] = 3'b000;
         req_addr[d]   = '0;
         req_wdata[d]  = '0;
         ref_rdata[d]  = '0;
      end

      // Reset values
      #12;
      for (int d = 0; d < NI; d++) begin
         cur_d = d;
         check("rst_req_ready", 32'(req_ready[d]), 32'd0);
         check("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
         check("rst_resp_rdata", resp_rdata[d], 32'd0);
         check("rst_flags", 32'({resp_misaligned[d], resp_illegal[d]}), 32'd0);
         check("rst_mem_address", 32'(mem_address[d]), 32'd0);
         check("rst_mem_data", mem_data[d], 32'd0);
         check("rst_mem_byteena", 32'(mem_byteena[d]), 32'd0);
         check("rst_mem_en", 32'({mem_rden[d], mem_wren[d]}), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      cur_d = 0;
      check("ready_before_edge", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
      for (int d = 0; d < NI; d++) begin
         cur_d = d;
         check("ready_after_release", 32'(req_ready[d]), 32'd1);
      end

      // Byte/half stores and sign/zero-extended loads on both latencies
      for (int d = 0; d < NI; d++) begin
         run_req(d, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
         run_req(d, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
         cur_d = d;
         check("lb_0x103", resp_rdata[d], 32'hFFFF_FFA5);
         run_req(d, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
         cur_d = d;
         check("lbu_0x103", resp_rdata[d], 32'h0000_00A5);
         run_req(d, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_8012);
         run_req(d, 1'b0, 3'b101, 32'h0000_0102, 32'h0);
         cur_d = d;
         check("lhu_0x102", resp_rdata[d], 32'h0000_8012);
         run_req(d, 1'b0, 3'b001, 32'h0000_0102, 32'h0);
         run_req(d, 1'b1, 3'b010, 32'hFFFF_C104, 32'h1234_5678);
         run_req(d, 1'b0, 3'b010, 32'h0000_0104, 32'h0);
         run_req(d, 1'b0, 3'b001, 32'h0000_0201, 32'h0);
         run_req(d, 1'b0, 3'b011, 32'h0000_0100, 32'h0);
         run_req(d, 1'b1, 3'b100, 32'h0000_0100, 32'h0);
         run_req(d, 1'b0, 3'b011, 32'h0000_0101, 32'h0);
         run_req(d, 1'b1, 3'b110, 32'h0000_0103, 32'h0);
         run_req(d, 1'b1, 3'b010, 32'h0000_0106, 32'h0);
      end

      // Random traffic over a small window with random upper address bits
      for (int t = 0; t < 200; t++) begin
         ra = $urandom;
         ra[13:6] = '0;
         run_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), ra, $urandom);
      end

      // Back-to-back word loads with req_valid held high, latency 2
      a   = 32'h0000_0010;
      b   = 32'h0000_0024;
      lda = model_load(1, 3'b010, a);
      ldb = model_load(1, 3'b010, b);
      wait_ready(1);
      req_valid[1]  = 1'b1;
      req_we[1]     = 1'b0;
      req_funct3[1] = 3'b010;
      req_addr[1]   = a;
      @(posedge clk); #1;
      req_addr[1]   = b;
      for (int c = 1; c <= 10; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         check("b2b_ready", 32'(req_ready[1]), 32'(c == 5 || c == 10));
         check("b2b_rden", 32'(mem_rden[1]), 32'(c == 1 || c == 2 || c == 6 || c == 7));
         check("b2b_valid", 32'(resp_valid[1]), 32'(c == 4 || c == 9));
         if (c == 3) begin
            check("b2b_be_capture_a", 32'(mem_byteena[1]), 32'h0000_000F);
            check("b2b_addr_capture_a", 32'(mem_address[1]), a >> 2);
         end
         if (c == 4) check("b2b_rdata_a", resp_rdata[1], lda);
         if (c == 6) begin
            check("b2b_addr_b", 32'(mem_address[1]), b >> 2);
            req_valid[1] = 1'b0;
         end
         if (c == 8) check("b2b_be_capture_b", 32'(mem_byteena[1]), 32'h0000_000F);
         if (c == 9) check("b2b_rdata_b", resp_rdata[1], ldb);
      end
      ref_rdata[1] = ldb;

      // Reset during the write cycle of a word store
      wait_ready(0);
      req_valid[0]  = 1'b1;
      req_we[0]     = 1'b1;
      req_funct3[0] = 3'b010;
      req_addr[0]   = 32'h0000_0040;
      req_wdata[0]  = 32'hCAFE_F00D;
      @(posedge clk); #1;
      req_valid[0]  = 1'b0;
      check("rst_mid_wren_before", 32'(mem_wren[0]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_wren_drop", 32'(mem_wren[0]), 32'd0);
      check("rst_mid_ready", 32'(req_ready[0]), 32'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("rst_hold_valid", 32'(resp_valid[0]), 32'd0);
         check("rst_hold_ready", 32'(req_ready[0]), 32'd0);
         check("rst_hold_wren", 32'(mem_wren[0]), 32'd0);
      end
      rst_n = 1'b1;
      #1;
      check("rst_rel_ready_low", 32'(req_ready[0]), 32'd0);
      @(posedge clk); #1;
      check("rst_rel_ready", 32'(req_ready[0]), 32'd1);
      check("rst_rel_valid", 32'(resp_valid[0]), 32'd0);
      ref_rdata[0] = '0;
      ref_rdata[1] = '0;
      run_req(0, 1'b0, 3'b010, 32'h0000_0042, 32'h0);
      run_req(1, 1'b0, 3'b001, 32'h0000_0003, 32'h0);
      run_req(0, 1'b0, 3'b010, 32'h0000_0040, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store controller sitting between the RV32I multicycle core's memory stage and the four-lane byte-banked data memory (port A). It takes one byte-addressed load/store request at a time and produces the memory's word address, lane-replicated write data and 4-bit byte enable. It sequences the memory's read latency, then extracts, aligns and sign- or zero-extends load data. Misaligned and illegal accesses are rejected without touching memory.

## Interface
- `XLEN`, 32: data width; fixed at 32.
- `DMEM_WIDTH`, 12: word-address width of the data memory.
- `READ_LATENCY`, 1: cycles from address/rden presentation to valid `mem_q`; legal values are 1 and 2.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller idle; request accepted on a rising edge with `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in XLEN: byte address.
- `req_wdata` in XLEN: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out XLEN: extended load result; holds until the next load completes.
- `resp_misaligned` out 1: qualifies `resp_valid`; access was misaligned.
- `resp_illegal` out 1: qualifies `resp_valid`; funct3 encoding was illegal.
- `mem_address` out DMEM_WIDTH: word address, equal to `req_addr[DMEM_WIDTH+1:2]`.
- `mem_data` out XLEN: lane-replicated store data.
- `mem_byteena` out 4: lane enables.
- `mem_rden` out 1: memory read enable.
- `mem_wren` out 1: memory write enable.
- `mem_q` in XLEN: memory read data. Lanes with byte enable deasserted read as 0.

## Operation
- FSM states and transitions:
  - IDLE → WRITE (legal aligned store), READ (legal aligned load) or ERR (misaligned or illegal).
  - WRITE → DONE.
  - READ → CAPTURE after READ_LATENCY cycles.
  - CAPTURE → DONE.
  - ERR → IDLE.
  - DONE → IDLE.
- Request fields are captured into registers on acceptance. Later changes on `req_*` are ignored.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else sets `resp_illegal`. Illegal takes priority over misaligned.
- Misaligned: halfword with `addr[0]` = 1; word with `addr[1:0]` ≠ 00. Bytes are never misaligned.
- Byte enables: SB = 0001 << `addr[1:0]`; SH = 0011 when `addr[1]` = 0, else 1100; SW and LW = 1111. Loads use the same lane pattern as the matching store width.
- Write data: SB = {4{byte}}, SH = {2{half}}, SW = word.
- Load extract: select the byte or half at `addr[1:0]`, shift it to bit 0, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Address bits above `DMEM_WIDTH+1` are ignored, so addresses wrap modulo memory size.
- `mem_address`, `mem_byteena` and `mem_data` are registered and held constant from the WRITE/READ entry through CAPTURE. This is required because the memory masks `mem_q` by byte enable.

## Timing
- Cycle 0 is the acceptance edge.
- Store:
  - Cycle 1: `mem_wren` = 1 for exactly one cycle.
  - Cycle 2: `resp_valid` = 1.
- Load:
  - Cycles 1 through READ_LATENCY: `mem_rden` = 1.
  - Cycle 1+READ_LATENCY: `mem_q` is sampled at the end of this cycle.
  - Cycle 2+READ_LATENCY: `resp_valid` = 1 and `resp_rdata` is updated.
- Error: cycle 1 pulses `resp_valid` with the flag set. No `mem_rden`/`mem_wren`; `resp_rdata` is unchanged.
- `req_ready` is registered:
  - It is 0 in all states except IDLE.
  - It returns to 1 in the cycle after `resp_valid`.
  - Minimum spacing between acceptances is therefore 3 cycles for stores, 3+READ_LATENCY for loads and 2 for errors.
- Reset values (all outputs 0): `req_ready`, `resp_valid`, `resp_rdata`, `resp_misaligned`, `resp_illegal`, `mem_address`, `mem_data`, `mem_byteena`, `mem_rden`, `mem_wren`.
- `req_ready` rises on the first rising edge after `rst_n` deasserts.
- Reset mid-operation: `mem_wren`/`mem_rden` drop immediately (asynchronous). The in-flight request is abandoned and never produces `resp_valid`.
- The flags are 0 whenever `resp_valid` is 0.

## Test plan
- SB, `addr` = 0x00000103, `wdata` = 0x000000A5 → cycle 1: `mem_address` = 0x040, `mem_byteena` = 1000, `mem_data` = 0xA5A5A5A5, `mem_wren` = 1 for one cycle; cycle 2: `resp_valid` = 1.
- LB at 0x103 with `mem_q` = 0xA5000000 (READ_LATENCY = 1) → `rden` in cycle 1, `resp_valid` in cycle 3 with `resp_rdata` = 0xFFFFFFA5. LBU → 0x000000A5. LHU at 0x102 with `mem_q` = 0x80120000 → 0x00008012.
- LH at 0x00000201 → cycle 1: `resp_valid` = 1 and `resp_misaligned` = 1; `mem_rden`/`mem_wren` stay 0; `resp_rdata` is unchanged.
- Load with funct3 = 011, and store with funct3 = 100 → `resp_illegal` = 1, no memory access. Illegal funct3 plus misaligned address → only `resp_illegal` is set.
- `req_valid` held high with two back-to-back LWs (READ_LATENCY = 2) → second request accepted exactly 5 cycles after the first; `mem_byteena` = 1111 held through the capture cycle.
- `rst_n` pulled low during cycle 1 of an SW → `mem_wren` falls within that cycle; no `resp_valid`; `req_ready` = 0 during reset and 1 one edge after release.
